// File: rtl/ex_pkg.sv
// Shared ALU operation codes for the EX stage and the control decoder.
package ex_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;

endpackage

// File: rtl/alu.sv
// Combinational LEGv8 ALU: computes result and zero flag from two operands.
module alu
    import ex_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   AluControl,
    output logic [N-1:0] result,
    output logic         zero
);

    always_comb begin
        result = '0;
        case (AluControl)
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_PASSB: result = b;
            ALU_NOR:   result = ~(a | b);
            // Unused codes yield 0 so nothing undefined reaches the pipeline.
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// LEGv8 execute stage: B-operand mux, ALU, branch-target adder and output registers.
module execute_stage
    import ex_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    output logic [N-1:0] PCBranch_E,
    output logic [N-1:0] aluResult_E,
    output logic [N-1:0] writeData_E,
    output logic         zero_E
);

    logic [N-1:0] alu_b;
    logic [N-1:0] alu_result;
    logic         alu_zero;

    logic [N-1:0] pc_branch_d, pc_branch_q;
    logic [N-1:0] alu_result_d, alu_result_q;
    logic [N-1:0] write_data_d, write_data_q;
    logic         zero_d, zero_q;

    assign alu_b = AluSrc ? signImm_E : readData2_E;

    alu #(
        .N(N)
    ) u_alu (
        .a         (readData1_E),
        .b         (alu_b),
        .AluControl(AluControl),
        .result    (alu_result),
        .zero      (alu_zero)
    );

    // Shift discards the top two immediate bits; the sum wraps modulo 2^N.
    always_comb begin
        pc_branch_d  = PC_E + (signImm_E << 2);
        alu_result_d = alu_result;
        write_data_d = readData2_E;
        zero_d       = alu_zero;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_branch_q  <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            zero_q       <= 1'b0;
        end else begin
            pc_branch_q  <= pc_branch_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            zero_q       <= zero_d;
        end
    end

    assign PCBranch_E  = pc_branch_q;
    assign aluResult_E = alu_result_q;
    assign writeData_E = write_data_q;
    assign zero_E      = zero_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage.
module tb_execute_stage;

    localparam int unsigned N = 64;

    logic         clk;
    logic         reset;
    logic         AluSrc;
    logic [3:0]   AluControl;
    logic [N-1:0] PC_E;
    logic [N-1:0] signImm_E;
    logic [N-1:0] readData1_E;
    logic [N-1:0] readData2_E;
    logic [N-1:0] PCBranch_E;
    logic [N-1:0] aluResult_E;
    logic [N-1:0] writeData_E;
    logic         zero_E;

    int checks;
    int failures;

    execute_stage #(
        .N(N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .AluSrc     (AluSrc),
        .AluControl (AluControl),
        .PC_E       (PC_E),
        .signImm_E  (signImm_E),
        .readData1_E(readData1_E),
        .readData2_E(readData2_E),
        .PCBranch_E (PCBranch_E),
        .aluResult_E(aluResult_E),
        .writeData_E(writeData_E),
        .zero_E     (zero_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic src, input logic [3:0] ctrl,
                         input logic [N-1:0] pc, input logic [N-1:0] imm,
                         input logic [N-1:0] rd1, input logic [N-1:0] rd2);
        @(negedge clk);
        reset       = rst;
        AluSrc      = src;
        AluControl  = ctrl;
        PC_E        = pc;
        signImm_E   = imm;
        readData1_E = rd1;
        readData2_E = rd2;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        AluSrc      = 1'b0;
        AluControl  = 4'b0010;
        PC_E        = 64'h100;
        signImm_E   = 64'h5;
        readData1_E = 64'h3;
        readData2_E = 64'h4;

        // Reset held for two edges with nonzero inputs.
        edge_sample();
        edge_sample();
        check("rst_alu", aluResult_E, 64'h0);
        check("rst_pcb", PCBranch_E, 64'h0);
        check("rst_wd", writeData_E, 64'h0);
        check("rst_zero", {63'h0, zero_E}, 64'h0);

        drive(1'b1, 1'b0, 4'b0010, 64'h0, 64'h0, 64'd5, 64'd7);
        edge_sample();
        check("add_res", aluResult_E, 64'd12);
        check("add_zero", {63'h0, zero_E}, 64'h0);
        check("add_wd", writeData_E, 64'd7);

        drive(1'b1, 1'b0, 4'b0110, 64'h0, 64'h0, 64'h1234, 64'h1234);
        edge_sample();
        check("sub_res", aluResult_E, 64'h0);
        check("sub_zero", {63'h0, zero_E}, 64'h1);

        drive(1'b1, 1'b1, 4'b0010, 64'h100, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'h99);
        edge_sample();
        check("imm_res", aluResult_E, 64'h8);
        check("imm_pcb", PCBranch_E, 64'hE0);
        check("imm_wd", writeData_E, 64'h99);
        check("imm_zero", {63'h0, zero_E}, 64'h0);

        drive(1'b1, 1'b0, 4'b0000, 64'h0, 64'h0, 64'hF0F0, 64'hFF00);
        edge_sample();
        check("and_res", aluResult_E, 64'hF000);

        drive(1'b1, 1'b0, 4'b0001, 64'h0, 64'h0, 64'hF0F0, 64'hFF00);
        edge_sample();
        check("or_res", aluResult_E, 64'hFFF0);

        drive(1'b1, 1'b1, 4'b1100, 64'h0, 64'hFF00, 64'hF0F0, 64'h0);
        edge_sample();
        check("nor_res", aluResult_E, 64'hFFFF_FFFF_FFFF_000F);
        check("nor_wd", writeData_E, 64'h0);

        drive(1'b1, 1'b0, 4'b0111, 64'h0, 64'h0, 64'hF0F0, 64'h0);
        edge_sample();
        check("passb_res", aluResult_E, 64'h0);
        check("passb_zero", {63'h0, zero_E}, 64'h1);

        drive(1'b1, 1'b0, 4'b0111, 64'h0, 64'h0, 64'h0, 64'hABCD);
        edge_sample();
        check("passb2_res", aluResult_E, 64'hABCD);
        check("passb2_zero", {63'h0, zero_E}, 64'h0);

        drive(1'b1, 1'b0, 4'b1111, 64'h0, 64'h0, 64'hF0F0, 64'hFF00);
        edge_sample();
        check("bad_res", aluResult_E, 64'h0);
        check("bad_zero", {63'h0, zero_E}, 64'h1);

        drive(1'b1, 1'b0, 4'b0010, 64'h0, 64'h4000_0000_0000_0001,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
        edge_sample();
        check("wrap_res", aluResult_E, 64'h0);
        check("wrap_zero", {63'h0, zero_E}, 64'h1);
        check("wrap_pcb", PCBranch_E, 64'h4);

        // Inputs changed mid-cycle must not reach the outputs before the edge.
        drive(1'b1, 1'b0, 4'b0010, 64'h200, 64'h1, 64'd100, 64'd23);
        #1;
        check("hold_res", aluResult_E, 64'h0);
        check("hold_pcb", PCBranch_E, 64'h4);
        edge_sample();
        check("load_res", aluResult_E, 64'd123);
        check("load_pcb", PCBranch_E, 64'h204);

        // Reset mid-stream with live inputs clears on the following edge.
        drive(1'b0, 1'b0, 4'b0010, 64'h200, 64'h1, 64'd100, 64'd23);
        #1;
        check("prerst_res", aluResult_E, 64'd123);
        edge_sample();
        check("midrst_res", aluResult_E, 64'h0);
        check("midrst_pcb", PCBranch_E, 64'h0);
        check("midrst_wd", writeData_E, 64'h0);
        check("midrst_zero", {63'h0, zero_E}, 64'h0);

        drive(1'b1, 1'b0, 4'b0110, 64'h10, 64'h2, 64'd50, 64'd8);
        edge_sample();
        check("post_res", aluResult_E, 64'd42);
        check("post_pcb", PCBranch_E, 64'h18);
        check("post_wd", writeData_E, 64'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
